// File: rtl/sd_app_pkg.sv
// Shared types and constants for the SD-card application blocks.
// Holds the scheduler state encoding and the UART line-ending and "END" marker bytes.
package sd_app_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_CARD,
    S_LISTING,
    S_SEND_NAME,
    S_SEND_CR,
    S_SEND_LF,
    S_SEND_END,
    S_FINISH
  } sched_state_t;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  localparam int unsigned END_LEN = 5;
  localparam logic [7:0] END_STR [END_LEN] = '{8'h45, 8'h4E, 8'h44, CR, LF};

  function automatic logic [7:0] end_byte(input logic [2:0] i);
    return (i < 3'(END_LEN)) ? END_STR[i] : 8'h00;
  endfunction

endpackage

// File: rtl/name_line_buf.sv
// One-entry file-name buffer: captures a name and its length, and returns one byte per index.
// The full flag is set on capture and cleared when the scheduler frees the entry.
module name_line_buf #(
  parameter int unsigned MAX_NAME = 52,
  parameter int unsigned LEN_W    = 8,
  localparam int unsigned IDX_W   = $clog2(MAX_NAME)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  capture,
  input  logic                  free,
  input  logic [MAX_NAME*8-1:0] name_in,
  input  logic [LEN_W-1:0]      len_in,
  input  logic [IDX_W-1:0]      idx,
  output logic                  full,
  output logic [LEN_W-1:0]      len,
  output logic [7:0]            rd_byte
);

  logic [MAX_NAME*8-1:0] name_q;

  // Names longer than the storage are truncated to MAX_NAME bytes.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      full <= 1'b0;
      len  <= '0;
    end else if (capture) begin
      full <= 1'b1;
      len  <= (len_in > LEN_W'(MAX_NAME)) ? LEN_W'(MAX_NAME) : len_in;
    end else if (free) begin
      full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      name_q <= name_in;
    end
  end

  assign rd_byte = name_q[{idx, 3'b000} +: 8];

endmodule

// File: rtl/sd_list_uart_sched.sv
// Sequences the SD file-list reader and prints each listed name to the UART as "name\r\n",
// followed by "END\r\n" once the reader reports done and the name buffer has drained.
module sd_list_uart_sched
  import sd_app_pkg::*;
#(
  parameter int unsigned MAX_NAME = 52,
  parameter int unsigned LEN_W    = 8,
  parameter int unsigned FNUM_W   = 13,
  parameter int unsigned DROP_W   = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [1:0]            card_type,
  output logic                  sd_op,
  input  logic                  sd_done,
  input  logic                  list_en,
  input  logic [MAX_NAME*8-1:0] list_name,
  input  logic [LEN_W-1:0]      list_namelen,
  input  logic [FNUM_W-1:0]     list_file_num,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  done,
  output logic [FNUM_W-1:0]     printed_cnt,
  output logic [DROP_W-1:0]     dropped_cnt,
  output logic [FNUM_W-1:0]     last_file_num
);

  localparam int unsigned IDX_W = $clog2(MAX_NAME);

  sched_state_t     state, state_next;
  logic [IDX_W-1:0] idx;
  logic [2:0]       end_idx;
  logic             buf_full;
  logic [LEN_W-1:0] buf_len;
  logic [7:0]       buf_byte;
  logic             active, capture, drop, hs, last_byte, lf_done;

  assign active    = (state == S_LISTING) || (state == S_SEND_NAME) ||
                     (state == S_SEND_CR) || (state == S_SEND_LF);
  assign capture   = active && list_en && !buf_full;
  assign drop      = active && list_en && buf_full;
  assign hs        = tx_valid && tx_ready;
  assign last_byte = (LEN_W'(idx) == (buf_len - LEN_W'(1)));
  // The buffer frees on the LF handshake edge, so a list_en on that edge still sees it full.
  assign lf_done   = (state == S_SEND_LF) && hs;

  name_line_buf #(
    .MAX_NAME (MAX_NAME),
    .LEN_W    (LEN_W)
  ) u_buf (
    .clk     (clk),
    .rstn    (rstn),
    .capture (capture),
    .free    (lf_done),
    .name_in (list_name),
    .len_in  (list_namelen),
    .idx     (idx),
    .full    (buf_full),
    .len     (buf_len),
    .rd_byte (buf_byte)
  );

  always_ff @(posedge clk) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:      if (start) state_next = S_WAIT_CARD;
      S_WAIT_CARD: if (card_type != 2'd0) state_next = S_LISTING;
      S_LISTING: begin
        if (buf_full)     state_next = S_SEND_NAME;
        else if (sd_done) state_next = S_SEND_END;
      end
      S_SEND_NAME: if ((buf_len == '0) || (hs && last_byte)) state_next = S_SEND_CR;
      S_SEND_CR:   if (hs) state_next = S_SEND_LF;
      S_SEND_LF:   if (hs) state_next = S_LISTING;
      S_SEND_END:  if (hs && (end_idx == 3'(END_LEN - 1))) state_next = S_FINISH;
      S_FINISH:    state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  always_comb begin
    sd_op    = active;
    busy     = (state != S_IDLE);
    done     = (state == S_FINISH);
    tx_valid = 1'b0;
    tx_data  = '0;
    unique case (state)
      S_SEND_NAME: begin
        tx_valid = (buf_len != '0);
        tx_data  = buf_byte;
      end
      S_SEND_CR: begin
        tx_valid = 1'b1;
        tx_data  = CR;
      end
      S_SEND_LF: begin
        tx_valid = 1'b1;
        tx_data  = LF;
      end
      S_SEND_END: begin
        tx_valid = 1'b1;
        tx_data  = end_byte(end_idx);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      idx           <= '0;
      end_idx       <= '0;
      printed_cnt   <= '0;
      dropped_cnt   <= '0;
      last_file_num <= '0;
    end else begin
      idx     <= (state == S_SEND_NAME) ? (hs ? idx + IDX_W'(1) : idx) : '0;
      end_idx <= (state == S_SEND_END) ? (hs ? end_idx + 3'd1 : end_idx) : '0;
      if ((state == S_IDLE) && start) begin
        printed_cnt <= '0;
        dropped_cnt <= '0;
      end else begin
        if (lf_done) printed_cnt <= printed_cnt + FNUM_W'(1);
        if (drop && (dropped_cnt != '1)) dropped_cnt <= dropped_cnt + DROP_W'(1);
      end
      if (capture) last_file_num <= list_file_num;
    end
  end

endmodule

// File: tb/tb_sd_list_uart_sched.sv
// Randomized self-checking bench for sd_list_uart_sched against a line-level model of the
// expected UART byte stream and run counters.
module tb_sd_list_uart_sched;

  localparam int MAX_NAME = 52;
  localparam int LEN_W    = 8;
  localparam int FNUM_W   = 13;
  localparam int DROP_W   = 8;

  logic                  clk = 1'b0;
  logic                  rstn, start, sd_op, sd_done, list_en;
  logic [1:0]            card_type;
  logic [MAX_NAME*8-1:0] list_name;
  logic [LEN_W-1:0]      list_namelen;
  logic [FNUM_W-1:0]     list_file_num, printed_cnt, last_file_num;
  logic [7:0]            tx_data;
  logic                  tx_valid, tx_ready, busy, done;
  logic [DROP_W-1:0]     dropped_cnt;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int hold_err = 0;
  int exp_printed, exp_dropped, exp_fnum, done_base;
  int cmp_base = 0;
  bit rand_ready = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic       sdop_q[$];
  logic       hold_pend = 1'b0;
  logic [7:0] hold_data = '0;

  always #5 clk = ~clk;

  sd_list_uart_sched #(
    .MAX_NAME (MAX_NAME),
    .LEN_W    (LEN_W),
    .FNUM_W   (FNUM_W),
    .DROP_W   (DROP_W)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .start         (start),
    .card_type     (card_type),
    .sd_op         (sd_op),
    .sd_done       (sd_done),
    .list_en       (list_en),
    .list_name     (list_name),
    .list_namelen  (list_namelen),
    .list_file_num (list_file_num),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .busy          (busy),
    .done          (done),
    .printed_cnt   (printed_cnt),
    .dropped_cnt   (dropped_cnt),
    .last_file_num (last_file_num)
  );

  // Inputs change 1 time unit after posedge; the monitor samples on negedge.
  always @(negedge clk) begin
    if (hold_pend && (!tx_valid || tx_data != hold_data)) hold_err++;
    hold_pend = rstn && tx_valid && !tx_ready;
    hold_data = tx_data;
    if (rstn && tx_valid && tx_ready) begin
      got_q.push_back(tx_data);
      sdop_q.push_back(sd_op);
    end
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
  endtask

  function automatic logic [MAX_NAME*8-1:0] rand_name();
    logic [MAX_NAME*8-1:0] n;
    for (int i = 0; i < MAX_NAME; i++) n[i*8 +: 8] = 8'(8'h41 + $urandom_range(0, 25));
    return n;
  endfunction

  task automatic expect_line(input logic [MAX_NAME*8-1:0] n, input int len);
    int l;
    l = (len > MAX_NAME) ? MAX_NAME : len;
    for (int i = 0; i < l; i++) exp_q.push_back(n[i*8 +: 8]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic send_entry(input logic [MAX_NAME*8-1:0] n, input int len, input int fnum,
                            input bit accepted);
    list_en       = 1'b1;
    list_name     = n;
    list_namelen  = LEN_W'(len);
    list_file_num = FNUM_W'(fnum);
    if (accepted) begin
      expect_line(n, len);
      exp_fnum = fnum;
      exp_printed++;
    end else begin
      exp_dropped++;
    end
    tick();
    list_en = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (got_q.size() < exp_q.size() && n < 3000) begin
      tick();
      n++;
    end
    check(tag, got_q.size(), exp_q.size());
  endtask

  task automatic wait_sent(input int cnt);
    int n;
    int target;
    n = 0;
    target = got_q.size() + cnt;
    while (got_q.size() < target && n < 500) begin
      tick();
      n++;
    end
  endtask

  task automatic start_run();
    exp_printed = 0;
    exp_dropped = 0;
    done_base   = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_sd_op(input string tag);
    int n;
    n = 0;
    while (!sd_op && n < 4) begin
      tick();
      n++;
    end
    check(tag, sd_op, 1'b1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_sd_op"},    sd_op, 0);
    check({tag, "_tx_valid"}, tx_valid, 0);
    check({tag, "_busy"},     busy, 0);
    check({tag, "_done"},     done, 0);
    check({tag, "_tx_data"},  tx_data, 0);
    check({tag, "_printed"},  printed_cnt, 0);
    check({tag, "_dropped"},  dropped_cnt, 0);
    check({tag, "_last"},     last_file_num, 0);
  endtask

  task automatic finish_run(input string tag);
    int n;
    int end_pos;
    wait_drain({tag, "_drain"});
    end_pos = exp_q.size();
    sd_done = 1'b1;
    exp_q.push_back(8'h45);
    exp_q.push_back(8'h4E);
    exp_q.push_back(8'h44);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    n = 0;
    while (busy && n < 2000) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, busy, 0);
    sd_done = 1'b0;
    tick();
    check({tag, "_nbytes"}, got_q.size(), exp_q.size());
    for (int i = cmp_base; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i - cmp_base), got_q[i], exp_q[i]);
    if (got_q.size() > end_pos) check({tag, "_sd_op_before_end"}, sdop_q[end_pos], 0);
    check({tag, "_done_pulses"}, done_cnt - done_base, 1);
    check({tag, "_printed"}, printed_cnt, exp_printed);
    check({tag, "_dropped"}, dropped_cnt, exp_dropped);
    check({tag, "_last_fnum"}, last_file_num, exp_fnum);
    check({tag, "_hold"}, hold_err, 0);
    cmp_base = exp_q.size();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [MAX_NAME*8-1:0] nm;
    int n;
    int viol;
    rstn = 1'b0; start = 1'b0; card_type = 2'd0; sd_done = 1'b0; list_en = 1'b0;
    list_name = '0; list_namelen = '0; list_file_num = '0; tx_ready = 1'b1;
    exp_fnum = 0;
    tick();
    tick();
    check_reset("rst");
    rstn = 1'b1;
    tick();

    // Run 1: single "A.TXT" entry, exact latencies
    card_type = 2'd1;
    start_run();
    check("wait_sd_op", sd_op, 0);
    check("wait_busy", busy, 1);
    tick();
    check("start_to_sd_op", sd_op, 1);
    nm = '0;
    nm[7:0] = 8'h41; nm[15:8] = 8'h2E; nm[23:16] = 8'h54; nm[31:24] = 8'h58; nm[39:32] = 8'h54;
    send_entry(nm, 5, 7, 1'b1);
    check("cap_lat0", tx_valid, 0);
    tick();
    check("cap_lat1", tx_valid, 1);
    check("first_byte", tx_data, 8'h41);
    finish_run("r1");

    // Run 2: no card, then stall and random back-pressure
    card_type = 2'd0;
    start_run();
    viol = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (sd_op || tx_valid || !busy) viol++;
    end
    check("nocard_wait", viol, 0);
    card_type = 2'd2;
    wait_sd_op("card_sd_op");
    send_entry(rand_name(), 12, 100, 1'b1);
    wait_sent(3);
    tx_ready = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("stall_valid", tx_valid, 1);
    check("stall_hold", hold_err, 0);
    rand_ready = 1'b1;
    wait_drain("r2_e1");
    send_entry(rand_name(), 0, 101, 1'b1);
    wait_drain("r2_len0");
    send_entry(rand_name(), 60, 102, 1'b1);
    wait_drain("r2_len60");
    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(0, 5);
      for (int i = 0; i < n; i++) tick();
      send_entry(rand_name(), $urandom_range(0, 60), 200 + k, 1'b1);
      wait_drain("r2_rand");
    end
    finish_run("r2");
    rand_ready = 1'b0;
    tx_ready = 1'b1;

    // Run 3: drops while a name is in flight, and on the LF edge
    card_type = 2'd1;
    start_run();
    wait_sd_op("r3_sd_op");
    send_entry(rand_name(), 8, 300, 1'b1);
    n = 0;
    while (!tx_valid && n < 10) begin
      tick();
      n++;
    end
    send_entry(rand_name(), 5, 301, 1'b0);
    tick();
    send_entry(rand_name(), 5, 302, 1'b0);
    wait_drain("r3_drain1");
    check("r3_drop2", dropped_cnt, 2);
    check("r3_print1", printed_cnt, 1);
    send_entry(rand_name(), 4, 303, 1'b1);
    n = 0;
    while (!(tx_valid && tx_data == 8'h0A) && n < 20) begin
      tick();
      n++;
    end
    check("r3_lf_seen", tx_data, 8'h0A);
    send_entry(rand_name(), 3, 304, 1'b0);
    send_entry(rand_name(), 3, 305, 1'b1);
    finish_run("r3");

    // Run 4: reset in the middle of a name, then a clean run
    start_run();
    wait_sd_op("r4_sd_op");
    send_entry(rand_name(), 20, 400, 1'b1);
    wait_sent(3);
    rstn = 1'b0;
    tick();
    check_reset("midrst");
    rstn = 1'b1;
    while (exp_q.size() > got_q.size()) void'(exp_q.pop_back());
    cmp_base = exp_q.size();
    tick();
    check("midrst_idle", busy, 0);
    start_run();
    wait_sd_op("r4b_sd_op");
    send_entry(rand_name(), 6, 401, 1'b1);
    finish_run("r4");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
